alu_deserializer: RTL



---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_crc4.sv | 24 ++
 rtl/alu_deserializer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the serial ALU receive path.
`default_nettype none

package alu_pkg;

  localparam int DATA_PKTS_DEFAULT = 8;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CMD  = 1'b1;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  typedef enum logic [1:0] {
    RX_IDLE      = 2'd0,
    RX_BITS      = 2'd1,
    RX_FRAME_ERR = 2'd2
  } rx_state_t;

  function automatic logic op_is_valid(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_crc4.sv
// alu_crc4: combinational CRC-4 (x^4+x+1, init 0, MSB first) over a 68-bit word (rev 1.0).
`default_nettype none

module alu_crc4 (
  input  logic [67:0] data,
  output logic [3:0]  crc
);

  function automatic logic [3:0] crc4_calc(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return c;
  endfunction

  assign crc = crc4_calc(data);

endmodule

`default_nettype wire

// File: rtl/alu_deserializer.sv
// alu_deserializer: serial packet receiver feeding the ALU core over valid/ready (rev 1.0).
// Optional CRC check enabled by defining ALU_DESER_CRC_EN.
`default_nettype none

module alu_deserializer
  import alu_pkg::*;
#(
  parameter int DATA_PKTS = DATA_PKTS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        overrun
);

  localparam int CW = $clog2(DATA_PKTS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_PKTS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_PKTS + 1);

  rx_state_t       state, state_nx;
  logic [3:0]      bit_cnt;
  logic [8:0]      shreg;
  logic [63:0]     asm_q;
  logic [CW-1:0]   pkt_cnt;
  logic            ferr_pend;

  logic            stop_now, pkt_done, frame_bad, cmd_done, data_done;
  logic [2:0]      cmd_op;
  logic [3:0]      cmd_crc;
  logic            err_data, err_crc, err_op, any_err;
  logic [2:0]      err_vec;
  logic            out_free;

  // shreg holds {type, payload[7:0]} once the stop bit is on the line
  assign stop_now  = (state == RX_BITS) && (bit_cnt == 4'd10);
  assign pkt_done  = stop_now && sin;
  assign frame_bad = stop_now && !sin;
  assign cmd_done  = pkt_done && (shreg[8] == PKT_CMD);
  assign data_done = pkt_done && (shreg[8] == PKT_DATA);
  assign cmd_op    = shreg[6:4];
  assign cmd_crc   = shreg[3:0];

  assign err_data = (pkt_cnt != CNT_FULL) || ferr_pend;
  assign err_op   = !op_is_valid(cmd_op);

`ifdef ALU_DESER_CRC_EN
  logic [3:0] crc_calc;

  alu_crc4 u_crc4 (
    .data ({asm_q, 1'b1, cmd_op}),
    .crc  (crc_calc)
  );

  assign err_crc = (crc_calc != cmd_crc);
`else
  assign err_crc = 1'b0;
`endif

  always_comb begin
    err_vec = 3'b000;
    if (err_data)     err_vec[ERR_DATA_BIT] = 1'b1;
    else if (err_crc) err_vec[ERR_CRC_BIT]  = 1'b1;
    else if (err_op)  err_vec[ERR_OP_BIT]   = 1'b1;
  end

  assign any_err  = |err_vec;
  assign out_free = !out_valid || out_ready;

  always_comb begin
    state_nx = state;
    case (state)
      RX_IDLE:      if (!sin) state_nx = RX_BITS;
      RX_BITS:      if (bit_cnt == 4'd10) state_nx = sin ? RX_IDLE : RX_FRAME_ERR;
      RX_FRAME_ERR: if (sin) state_nx = RX_IDLE;
      default:      state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= 4'd0;
      shreg     <= 9'd0;
      asm_q     <= 64'd0;
      pkt_cnt   <= '0;
      ferr_pend <= 1'b0;
    end else begin
      if (state == RX_IDLE)      bit_cnt <= 4'd1;
      else if (state == RX_BITS) bit_cnt <= bit_cnt + 4'd1;

      if ((state == RX_BITS) && (bit_cnt != 4'd10))
        shreg <= {shreg[7:0], sin};

      if (frame_bad) begin
        asm_q     <= 64'd0;
        pkt_cnt   <= '0;
        ferr_pend <= 1'b1;
      end else if (data_done) begin
        asm_q <= {asm_q[55:0], shreg[7:0]};
        if (pkt_cnt != CNT_SAT) pkt_cnt <= pkt_cnt + 1'b1;
      end else if (cmd_done) begin
        asm_q     <= 64'd0;
        pkt_cnt   <= '0;
        ferr_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= 32'd0;
      out_b     <= 32'd0;
      out_op    <= 3'd0;
      out_err   <= 3'd0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (cmd_done && out_free) begin
        out_valid <= 1'b1;
        out_a     <= any_err ? 32'd0 : asm_q[31:0];
        out_b     <= any_err ? 32'd0 : asm_q[63:32];
        out_op    <= any_err ? 3'd0  : cmd_op;
        out_err   <= err_vec;
      end else begin
        if (cmd_done) overrun <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
